// File: rtl/kbd_scancode_fifo.sv
// kbd_scancode_fifo: buffers PS/2 scancodes in a DEPTH x 8 circular FIFO and
// exposes them to the OTTER MCU as memory-mapped IO.
// Latency: a scancode is visible on RD_DATA and INTR pulses one edge after the
// KBD_INTRPT rising edge is sampled.
// Backpressure: when the FIFO is full, a push with no simultaneous pop is dropped
// and the sticky OVERFLOW flag is set.
// Ports: CLK/RST_N (async active-low); KBD_INTRPT/SCANCODE from the keyboard driver;
//        IOBUS_ADDR/RD/WR/OUT from the MCU; RD_DATA to the IOBUS input mux;
//        INTR is a one-cycle pulse per accepted scancode.
// Option: define KBD_BREAK_FILTER_EN to drop 0xF0 and the byte that follows it,
//         so only make codes reach the CPU.
module kbd_scancode_fifo #(
    parameter int          DEPTH   = 16,
    parameter logic [31:0] DATA_AD = 32'h11000100,
    parameter logic [31:0] STAT_AD = 32'h11000104
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        KBD_INTRPT,
    input  logic [7:0]  SCANCODE,
    input  logic [31:0] IOBUS_ADDR,
    input  logic        IOBUS_RD,
    input  logic        IOBUS_WR,
    input  logic [31:0] IOBUS_OUT,
    output logic [31:0] RD_DATA,
    output logic        INTR
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          intr_q, intr_d;
    logic          kbd_q;

    logic push_evt, push_req, pop_req, push_ok;
    logic flush, clr_ovf, ovf_set;
    logic empty, full;
    logic [4:0] cnt5;
    logic unused_ok;

    // Only bits [1:0] of a status write carry meaning.
    assign unused_ok = ^IOBUS_OUT[31:2];

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign push_evt = KBD_INTRPT & ~kbd_q;

`ifdef KBD_BREAK_FILTER_EN
    typedef enum logic {F_IDLE, F_BREAK} filt_e;
    filt_e filt_q, filt_d;

    // 0xF0 arms the filter; the following break-code byte is swallowed.
    always_comb begin
        filt_d   = filt_q;
        push_req = 1'b0;
        if (push_evt) begin
            case (filt_q)
                F_IDLE: begin
                    if (SCANCODE == 8'hF0) filt_d = F_BREAK;
                    else                   push_req = 1'b1;
                end
                F_BREAK: filt_d = F_IDLE;
                default: filt_d = F_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) filt_q <= F_IDLE;
        else        filt_q <= filt_d;
    end
`else
    assign push_req = push_evt;
`endif

    assign pop_req = IOBUS_RD & (IOBUS_ADDR == DATA_AD) & ~empty;
    assign flush   = IOBUS_WR & (IOBUS_ADDR == STAT_AD) & IOBUS_OUT[1];
    assign clr_ovf = IOBUS_WR & (IOBUS_ADDR == STAT_AD) & IOBUS_OUT[0];
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push_req & ~flush & (~full | pop_req);
    assign ovf_set = push_req & ~flush & full & ~pop_req;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        intr_d  = push_ok;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_req) head_d = head_q + AW'(1);
            if (push_ok) tail_d = tail_q + AW'(1);
            if (push_ok && !pop_req)      count_d = count_q + CW'(1);
            else if (!push_ok && pop_req) count_d = count_q - CW'(1);
        end
        // Set takes priority over a clear in the same cycle.
        if (clr_ovf) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            intr_q  <= 1'b0;
            kbd_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            intr_q  <= intr_d;
            kbd_q   <= KBD_INTRPT;
        end
    end

    // Storage needs no reset: entries are only readable while count says so.
    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[tail_q] <= SCANCODE;
    end

    assign cnt5 = 5'(count_q);

    always_comb begin
        RD_DATA = '0;
        if (IOBUS_ADDR == DATA_AD) begin
            if (!empty) RD_DATA = {23'b0, 1'b1, mem_q[head_q]};
        end else if (IOBUS_ADDR == STAT_AD) begin
            RD_DATA = {19'b0, cnt5, 5'b0, ovf_q, full, empty};
        end
    end

    assign INTR = intr_q;

endmodule
